// File: rtl/instr_encoder.sv
// RV32I instruction encoder that streams encoded words into instruction memory.
// Define INSTR_ENC_CHECK_EN to reject illegal descriptors instead of writing NOPs.
module instr_encoder #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  CPU_CLK,
    input  logic                  CPU_RST_N,
    input  logic                  Start,
    input  logic                  Finish,
    input  logic [DEPTH_LOG2-1:0] BaseAddr,
    input  logic                  EncValid,
    output logic                  EncReady,
    input  logic [3:0]            Class,
    input  logic [3:0]            Fn,
    input  logic [4:0]            Rd,
    input  logic [4:0]            Rs1,
    input  logic [4:0]            Rs2,
    input  logic [31:0]           Imm,
    output logic                  InstrWE,
    output logic [DEPTH_LOG2-1:0] InstrAddr,
    output logic [31:0]           InstrWData,
    output logic                  Busy,
    output logic                  Full,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Err
);

    // ALU operation codes shared with the core's Parameters.v
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [DEPTH_LOG2:0] LAST_CNT = {1'b0, {DEPTH_LOG2{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                r_state;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_we;
    logic [DEPTH_LOG2-1:0] r_waddr;
    logic [31:0]           r_wdata;

    logic       w_accept;
    logic       w_commit;
    logic       w_alu_ok;
    logic       w_alt;
    logic       w_shift;
    logic [2:0] w_alu_f3;
    logic       w_i12;
    logic       w_b13;
    logic       w_j21;
    logic       w_sh;
    logic       w_legal;
    logic [31:0] w_word;
    logic [31:0] w_data;

    assign EncReady = (r_state == S_RUN) & ~Start & ~Finish;
    assign w_accept = EncValid & EncReady;

    always_comb begin
        w_alu_ok = 1'b1;
        w_alt    = 1'b0;
        w_shift  = 1'b0;
        w_alu_f3 = 3'b000;
        case (Fn)
            ALU_ADD:  w_alu_f3 = 3'b000;
            ALU_SUB:  w_alt    = 1'b1;
            ALU_SLL:  begin w_alu_f3 = 3'b001; w_shift = 1'b1; end
            ALU_SLT:  w_alu_f3 = 3'b010;
            ALU_SLTU: w_alu_f3 = 3'b011;
            ALU_XOR:  w_alu_f3 = 3'b100;
            ALU_SRL:  begin w_alu_f3 = 3'b101; w_shift = 1'b1; end
            ALU_SRA:  begin w_alu_f3 = 3'b101; w_shift = 1'b1; w_alt = 1'b1; end
            ALU_OR:   w_alu_f3 = 3'b110;
            ALU_AND:  w_alu_f3 = 3'b111;
            default:  w_alu_ok = 1'b0;
        endcase
    end

    // Signed range checks: all bits above the field must replicate its sign
    assign w_i12 = (Imm[31:11] == '0) | (Imm[31:11] == '1);
    assign w_b13 = (Imm[31:12] == '0) | (Imm[31:12] == '1);
    assign w_j21 = (Imm[31:20] == '0) | (Imm[31:20] == '1);
    assign w_sh  = (Imm[31:5] == '0);

    always_comb begin
        w_legal = 1'b0;
        w_word  = NOP;
        case (Class)
            4'd0: begin
                w_legal = w_alu_ok;
                w_word  = {1'b0, w_alt, 5'b0, Rs2, Rs1, w_alu_f3, Rd, OP_R};
            end
            4'd1: begin
                w_legal = w_alu_ok & (Fn != ALU_SUB) & (w_shift ? w_sh : w_i12);
                w_word  = w_shift
                        ? {1'b0, w_alt, 5'b0, Imm[4:0], Rs1, w_alu_f3, Rd, OP_I}
                        : {Imm[11:0], Rs1, w_alu_f3, Rd, OP_I};
            end
            4'd2: begin
                w_legal = ~Fn[3] & w_i12 & (Fn[2:0] != 3'b011)
                        & (Fn[2:1] != 2'b11);
                w_word  = {Imm[11:0], Rs1, Fn[2:0], Rd, OP_LOAD};
            end
            4'd3: begin
                w_legal = ~Fn[3] & w_i12 & (Fn[2:0] <= 3'b010);
                w_word  = {Imm[11:5], Rs2, Rs1, Fn[2:0], Imm[4:0], OP_STORE};
            end
            4'd4: begin
                w_legal = ~Fn[3] & w_b13 & ~Imm[0] & (Fn[2:1] != 2'b01);
                w_word  = {Imm[12], Imm[10:5], Rs2, Rs1, Fn[2:0],
                           Imm[4:1], Imm[11], OP_BR};
            end
            4'd5: begin
                w_legal = w_j21 & ~Imm[0];
                w_word  = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, OP_JAL};
            end
            4'd6: begin
                w_legal = w_i12;
                w_word  = {Imm[11:0], Rs1, 3'b000, Rd, OP_JALR};
            end
            4'd7: begin
                w_legal = 1'b1;
                w_word  = {Imm[31:12], Rd, OP_LUI};
            end
            4'd8: begin
                w_legal = 1'b1;
                w_word  = {Imm[31:12], Rd, OP_AUIPC};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = NOP;
            end
        endcase
    end

    assign w_data = w_legal ? w_word : NOP;

`ifdef INSTR_ENC_CHECK_EN
    logic r_err;
    assign w_commit = w_legal;
    assign Err      = r_err;
`else
    assign w_commit = 1'b1;
    assign Err      = 1'b0;
`endif

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
`ifdef INSTR_ENC_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            if (Start) begin
                r_state <= S_RUN;
                r_addr  <= BaseAddr;
                r_count <= '0;
`ifdef INSTR_ENC_CHECK_EN
                r_err   <= 1'b0;
`endif
            end else if (Finish) begin
                r_state <= S_IDLE;
            end else if (w_accept) begin
                if (w_commit) begin
                    r_we    <= 1'b1;
                    r_waddr <= r_addr;
                    r_wdata <= w_data;
                    r_addr  <= r_addr + 1'b1;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_CNT) r_state <= S_FULL;
                end
`ifdef INSTR_ENC_CHECK_EN
                else begin
                    r_err <= 1'b1;
                end
`endif
            end
        end
    end

    assign InstrWE    = r_we;
    assign InstrAddr  = r_waddr;
    assign InstrWData = r_wdata;
    assign Busy       = (r_state != S_IDLE);
    assign Full       = (r_state == S_FULL);
    assign Count      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: random descriptors vs a behavioural model.
// Honours INSTR_ENC_CHECK_EN the same way the design does.
module tb_instr_encoder;

    localparam int DL  = 5;
    localparam int DEP = 1 << DL;

`ifdef INSTR_ENC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_SLL = 4'd2;
    localparam logic [3:0] F_SRL = 4'd6, F_SRA = 4'd7;

    typedef struct {
        logic [3:0]  cls;
        logic [3:0]  fn;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } desc_t;

    typedef struct {
        logic [DL-1:0] a;
        logic [31:0]   w;
    } exp_t;

    logic          CPU_CLK = 1'b0;
    logic          CPU_RST_N;
    logic          Start, Finish, EncValid;
    logic [DL-1:0] BaseAddr;
    logic          EncReady;
    logic [3:0]    Class, Fn;
    logic [4:0]    Rd, Rs1, Rs2;
    logic [31:0]   Imm;
    logic          InstrWE;
    logic [DL-1:0] InstrAddr;
    logic [31:0]   InstrWData;
    logic          Busy, Full, Err;
    logic [DL:0]   Count;

    instr_encoder #(.DEPTH_LOG2(DL)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
        .Start(Start), .Finish(Finish), .BaseAddr(BaseAddr),
        .EncValid(EncValid), .EncReady(EncReady),
        .Class(Class), .Fn(Fn), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm),
        .InstrWE(InstrWE), .InstrAddr(InstrAddr), .InstrWData(InstrWData),
        .Busy(Busy), .Full(Full), .Count(Count), .Err(Err)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    int errs = 0;
    int checks = 0;
    exp_t exp_q[$];

    int m_state;
    int m_addr;
    int m_cnt;
    bit m_err;

    logic [6:0] opc_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                7'h6f, 7'h67, 7'h37, 7'h17};
    logic [2:0] alu_f3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
                                3'd4, 3'd5, 3'd5, 3'd6, 3'd7};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    function automatic desc_t mk(input int c, input int f, input int rd,
                                 input int rs1, input int rs2,
                                 input logic [31:0] imm);
        desc_t d;
        d.cls = 4'(c); d.fn = 4'(f); d.rd = 5'(rd);
        d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.imm = imm;
        return d;
    endfunction

    function automatic bit fits(input logic [31:0] x, input int bits);
        int signed v;
        v = $signed(x);
        return (v >= -(1 <<< (bits - 1))) && (v < (1 <<< (bits - 1)));
    endfunction

    function automatic bit is_shift(input logic [3:0] f);
        return f == F_SLL || f == F_SRL || f == F_SRA;
    endfunction

    function automatic bit legal(input desc_t d);
        int f3;
        f3 = int'(d.fn) % 8;
        case (int'(d.cls))
            0: return d.fn <= 9;
            1: begin
                if (d.fn > 9 || d.fn == F_SUB) return 0;
                if (is_shift(d.fn)) return d.imm < 32;
                return fits(d.imm, 12);
            end
            2: return d.fn < 8 && !(f3 inside {3, 6, 7}) && fits(d.imm, 12);
            3: return d.fn <= 2 && fits(d.imm, 12);
            4: return d.fn < 8 && !(f3 inside {2, 3}) && fits(d.imm, 13)
                      && d.imm[0] == 1'b0;
            5: return fits(d.imm, 21) && d.imm[0] == 1'b0;
            6: return fits(d.imm, 12);
            7, 8: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] enc(input desc_t d);
        logic [31:0] u, base, f7, f3;
        u    = d.imm;
        base = 32'(opc_tab[d.cls]) | (32'(d.rd) << 7) | (32'(d.rs1) << 15);
        f3   = 32'(d.fn[2:0]) << 12;
        case (int'(d.cls))
            0, 1: begin
                f7 = (d.fn == F_SUB || d.fn == F_SRA) ? 32'h40000000 : 32'h0;
                f3 = 32'(alu_f3[d.fn]) << 12;
                if (d.cls == 0) return base | f3 | (32'(d.rs2) << 20) | f7;
                if (is_shift(d.fn)) return base | f3 | ((u & 31) << 20) | f7;
                return base | f3 | ((u & 32'hfff) << 20);
            end
            2: return base | f3 | ((u & 32'hfff) << 20);
            3: return 32'h23 | f3 | (32'(d.rs1) << 15) | (32'(d.rs2) << 20)
                      | (((u >> 5) & 127) << 25) | ((u & 31) << 7);
            4: return 32'h63 | f3 | (32'(d.rs1) << 15) | (32'(d.rs2) << 20)
                      | (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25)
                      | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7);
            5: return 32'h6f | (32'(d.rd) << 7)
                      | (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21)
                      | (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12);
            6: return base | ((u & 32'hfff) << 20);
            default: return 32'(opc_tab[d.cls]) | (32'(d.rd) << 7)
                            | (u & 32'hfffff000);
        endcase
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        int m;
        d.cls = ($urandom % 16 == 0) ? 4'($urandom_range(9, 15))
                                     : 4'($urandom_range(0, 8));
        if (d.cls <= 1)
            d.fn = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15))
                                       : 4'($urandom_range(0, 9));
        else
            d.fn = ($urandom % 8 == 0) ? 4'($urandom_range(8, 15))
                                       : 4'($urandom_range(0, 7));
        d.rd  = 5'($urandom);
        d.rs1 = 5'($urandom);
        d.rs2 = 5'($urandom);
        m = $urandom_range(0, 5);
        d.imm = $urandom;
        if (m == 1) d.imm = {{20{d.imm[11]}}, d.imm[11:0]};
        if (m == 2) d.imm = {{19{d.imm[12]}}, d.imm[12:1], 1'b0};
        if (m == 3) d.imm = {{11{d.imm[20]}}, d.imm[20:1], 1'b0};
        if (m == 4) d.imm = d.imm & 32'h1f;
        return d;
    endfunction

    task automatic check_status();
        chk("busy", Busy, m_state != 0);
        chk("full", Full, m_state == 2);
        chk("count", 32'(Count), m_cnt);
        chk("err", Err, m_err);
    endtask

    // One clock of stimulus; model predicts the upcoming edge
    task automatic cycle(input bit st, input bit fin, input int base,
                         input bit v, input desc_t d, input bit use_exp,
                         input logic [31:0] expw, output bit acc);
        bit rdy;
        bit ok;
        exp_t e;
        @(negedge CPU_CLK);
        check_status();
        Start = st; Finish = fin; BaseAddr = DL'(base); EncValid = v;
        Class = d.cls; Fn = d.fn; Rd = d.rd; Rs1 = d.rs1; Rs2 = d.rs2;
        Imm = d.imm;
        #1;
        rdy = (m_state == 1) && !st && !fin;
        chk("enc_ready", EncReady, rdy);
        acc = rdy && v;
        if (st) begin
            m_state = 1; m_addr = base % DEP; m_cnt = 0; m_err = 0;
        end else if (fin) begin
            m_state = 0;
        end else if (acc) begin
            ok = legal(d);
            if (CHK && !ok) begin
                m_err = 1;
            end else begin
                e.a = DL'(m_addr);
                e.w = use_exp ? expw : (ok ? enc(d) : 32'h13);
                exp_q.push_back(e);
                m_addr = (m_addr + 1) % DEP;
                m_cnt++;
                if (m_cnt == DEP) m_state = 2;
            end
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0), 0, 0, a);
    endtask

    task automatic start(input int base);
        bit a;
        cycle(1, 0, base, 0, mk(0, 0, 0, 0, 0, 0), 0, 0, a);
    endtask

    task automatic send(input desc_t d, input bit use_exp, input logic [31:0] w);
        bit a;
        int k;
        a = 0;
        for (k = 0; k < 8 && !a; k++) cycle(0, 0, 0, 1, d, use_exp, w, a);
        if (!a) begin
            errs++; checks++;
            $display("FAIL send_timeout: got no accept want accept");
        end
    endtask

    task automatic check_all_zero();
        chk("rst_we", InstrWE, 0);
        chk("rst_addr", 32'(InstrAddr), 0);
        chk("rst_data", InstrWData, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_full", Full, 0);
        chk("rst_count", 32'(Count), 0);
        chk("rst_err", Err, 0);
        chk("rst_ready", EncReady, 0);
    endtask

    always @(posedge CPU_CLK) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_strobe", InstrWE, 1);
            chk("wr_addr", 32'(InstrAddr), 32'(e.a));
            chk("wr_data", InstrWData, e.w);
        end else if (InstrWE) begin
            chk("spurious_wr", InstrWE, 0);
        end
    end

    initial begin
        bit a;
        bit st, fin;
        desc_t d;
        int n;
        CPU_RST_N = 1'b1;
        Start = 0; Finish = 0; EncValid = 0; BaseAddr = '0;
        Class = 0; Fn = 0; Rd = 0; Rs1 = 0; Rs2 = 0; Imm = 0;
        m_state = 0; m_addr = 0; m_cnt = 0; m_err = 0;
        #2 CPU_RST_N = 1'b0;
        #1 check_all_zero();
        repeat (2) @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
        idle(2);

        start(16);
        send(mk(1, F_ADD, 1, 0, 0, 5), 1, 32'h00500093);
        send(mk(0, F_ADD, 3, 1, 2, 0), 1, 32'h002081B3);
        send(mk(3, 2, 0, 1, 2, 8), 1, 32'h0020A423);
        send(mk(4, 0, 0, 1, 2, 8), 1, 32'h00208463);
        send(mk(5, 0, 1, 0, 0, 16), 1, 32'h010000EF);
        send(mk(7, 0, 5, 0, 0, 32'h12345000), 1, 32'h123452B7);
        send(mk(4, 0, 0, 1, 2, 3), 1, 32'h00000013);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            st  = ($urandom % 40 == 0);
            fin = ($urandom % 50 == 0);
            if (m_state == 0 && $urandom % 4 == 0) st = 1;
            cycle(st, fin, $urandom_range(0, DEP - 1), ($urandom % 4) != 0,
                  rand_desc(), 0, 0, a);
        end
        idle(2);

        start(DEP - 3);
        n = 0;
        d = mk(1, F_ADD, 1, 2, 0, 32'($urandom_range(0, 2047)));
        for (int k = 0; k < DEP + 8 && n < DEP; k++) begin
            cycle(0, 0, 0, 1, d, 0, 0, a);
            if (a) begin
                n++;
                d = mk(1, F_ADD, $urandom_range(0, 31), $urandom_range(0, 31),
                       0, 32'($urandom_range(0, 2047)));
            end
        end
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, d, 0, 0, a);
        cycle(0, 1, 0, 1, d, 0, 0, a);
        idle(2);

        start(5);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, rand_desc(), 0, 0, a);
        @(posedge CPU_CLK);
        #3 CPU_RST_N = 1'b0;
        #1 check_all_zero();
        m_state = 0; m_addr = 0; m_cnt = 0; m_err = 0;
        repeat (2) @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, rand_desc(), 0, 0, a);
        start(9);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, rand_desc(), 0, 0, a);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
